// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO with count, full/empty flags and overflow/underflow reporting.
// Define STACK_ERR_STICKY_EN to make ovf/unf sticky until err_clr; otherwise they pulse one cycle.
module lifo_stack #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  input  logic              err_clr,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, full_q, ovf_q, unf_q;
  logic              ovf_d, unf_d;
  logic              do_push, do_pop, do_rep, we, ovf_ev, unf_ev;
  logic [AW-1:0]     waddr, raddr;
  always_comb begin
    do_push = push & ~full_q & ~(pop & ~empty_q);
    do_pop  = pop & ~push & ~empty_q;
    do_rep  = push & pop & ~empty_q;
    we      = do_push | do_rep;
    ovf_ev  = push & ~pop & full_q;
    unf_ev  = pop & ~push & empty_q;
    waddr   = AW'(do_rep ? count_q - 1'b1 : count_q);
    raddr   = AW'(count_q - CNT_W'(2));
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    dout_d  = we ? din : do_pop ? (count_q == CNT_W'(1) ? '0 : mem_q[raddr]) : dout_q;
  end
`ifdef STACK_ERR_STICKY_EN
  // A new error event on the same edge as err_clr keeps the flag set.
  assign ovf_d = ovf_ev | (ovf_q & ~err_clr);
  assign unf_d = unf_ev | (unf_q & ~err_clr);
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovf_d = ovf_ev;
  assign unf_d = unf_ev;
`endif
  always_ff @(posedge clk) begin
    if (rst_n && we) mem_q[waddr] <= din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      count_q <= count_d;
      empty_q <= count_d == '0;
      full_q  <= count_d == CNT_W'(DEPTH);
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  assign dout  = dout_q;
  assign count = count_q;
  assign empty = empty_q;
  assign full  = full_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed scenarios for lifo_stack (DATA_W=16, DEPTH=8, default pulse-error build).
module tb_lifo_stack;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [15:0] din = '0;
  logic        err_clr = 1'b0;
  logic [15:0] dout;
  logic [3:0]  count;
  logic        empty, full, ovf, unf;
  logic [23:0] obs, exp;
  int          errors = 0;
  int          checks = 0;

  lifo_stack #(.DATA_W(16), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din), .err_clr(err_clr),
    .dout(dout), .count(count), .empty(empty), .full(full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    obs = {dout, count, empty, full, ovf, unf};
    exp = {16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset got %h want %h", obs, exp); end
    pop = 1'b1;
    step();
    pop = 1'b0;
    obs = {dout, count, empty, full, ovf, unf};
    exp = {16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL pop_empty got %h want %h", obs, exp); end
    step();
    obs = {dout, count, empty, full, ovf, unf};
    exp = {16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL unf_pulse_end got %h want %h", obs, exp); end
  endtask

  task automatic test_fill_overflow;
    logic [15:0] vals [8] = '{16'hffaa, 16'hf66f, 16'hff9f, 16'h0000, 16'h666f, 16'h1234, 16'h9876, 16'habcd};
    for (int i = 0; i < 8; i++) begin
      push = 1'b1;
      din = vals[i];
      step();
      obs = {dout, count, empty, full, ovf, unf};
      exp = {vals[i], 4'(i + 1), 1'b0, i == 7, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL fill[%0d] got %h want %h", i, obs, exp); end
    end
    din = 16'h5555;
    step();
    push = 1'b0;
    obs = {dout, count, empty, full, ovf, unf};
    exp = {16'habcd, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL overflow got %h want %h", obs, exp); end
    step();
    obs = {dout, count, empty, full, ovf, unf};
    exp = {16'habcd, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ovf_pulse_end got %h want %h", obs, exp); end
  endtask

  task automatic test_drain_underflow;
    logic [15:0] tops [8] = '{16'h9876, 16'h1234, 16'h666f, 16'h0000, 16'hff9f, 16'hf66f, 16'hffaa, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1;
      step();
      obs = {dout, count, empty, full, ovf, unf};
      exp = {tops[i], 4'(7 - i), i == 7, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL drain[%0d] got %h want %h", i, obs, exp); end
    end
    step();
    pop = 1'b0;
    obs = {dout, count, empty, full, ovf, unf};
    exp = {16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL underflow got %h want %h", obs, exp); end
    step();
  endtask

  task automatic test_replace;
    logic [15:0] vin [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h0000};
    logic [1:0]  op  [4] = '{2'b10, 2'b10, 2'b11, 2'b01};
    logic [15:0] vd  [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h1111};
    logic [3:0]  vc  [4] = '{4'd1, 4'd2, 4'd2, 4'd1};
    for (int i = 0; i < 4; i++) begin
      {push, pop} = op[i];
      din = vin[i];
      step();
      obs = {dout, count, empty, full, ovf, unf};
      exp = {vd[i], vc[i], 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL replace[%0d] got %h want %h", i, obs, exp); end
    end
    {push, pop} = 2'b01;
    step();
    for (int i = 0; i < 8; i++) begin
      {push, pop} = 2'b10;
      din = 16'h0100 + 16'(i);
      step();
    end
    {push, pop} = 2'b11;
    din = 16'h7777;
    step();
    obs = {dout, count, empty, full, ovf, unf};
    exp = {16'h7777, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL replace_full got %h want %h", obs, exp); end
    {push, pop} = 2'b01;
    step();
    {push, pop} = 2'b00;
    obs = {dout, count, empty, full, ovf, unf};
    exp = {16'h0106, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL pop_after_replace got %h want %h", obs, exp); end
  endtask

  task automatic test_push_pop_empty;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    {push, pop} = 2'b11;
    din = 16'h4444;
    step();
    {push, pop} = 2'b00;
    obs = {dout, count, empty, full, ovf, unf};
    exp = {16'h4444, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL pushpop_empty got %h want %h", obs, exp); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 2; i++) begin
      push = 1'b1;
      din = 16'h00a0 + 16'(i);
      step();
    end
    push = 1'b0;
    obs = {dout, count, empty, full, ovf, unf};
    exp = {16'h00a1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL prefill got %h want %h", obs, exp); end
    rst_n = 1'b0;
    #2;
    obs = {dout, count, empty, full, ovf, unf};
    exp = {16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL async_reset got %h want %h", obs, exp); end
    rst_n = 1'b1;
    push = 1'b1;
    din = 16'hbeef;
    step();
    push = 1'b0;
    obs = {dout, count, empty, full, ovf, unf};
    exp = {16'hbeef, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL push_after_reset got %h want %h", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_replace();
    test_push_pop_empty();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parametrised synchronous LIFO stack: the next-generation push/pop stack memory with configurable data width and depth. It adds occupancy count, full/empty flags, overflow/underflow error reporting and a push+pop replace-top operation. It sits between a command-decoding front end and any consumer needing last-in/first-out buffering. All state is in one clock domain.

## Interface
- DATA_W, 16, width of each stack entry in bits
- DEPTH, 8, number of entries; must be ≥2
- CNT_W, $clog2(DEPTH+1), width of count (derived localparam, not overridable)

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- push  input  1  push request, sampled on rising edge of clk
- pop  input  1  pop request, sampled on rising edge of clk
- din  input  DATA_W  data to push
- err_clr  input  1  clears sticky error flags (used only when STACK_ERR_STICKY_EN is defined; ignored otherwise)
- dout  output  DATA_W  registered current top-of-stack value; 0 when empty
- count  output  CNT_W  number of valid entries, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- ovf  output  1  overflow error (push rejected)
- unf  output  1  underflow error (pop rejected)

## Operation
- Reset (rst_n low, asynchronous): count=0, empty=1, full=0, dout=0, ovf=0, unf=0. Storage array is not cleared. Reset mid-operation discards all contents. No write occurs on the edge where rst_n is low.
- Each edge, decode {push,pop}:
  - 00: hold all state.
  - 10, not full: write din at index count, count+1, dout←din.
  - 10, full: no write, count unchanged, ovf error event.
  - 01, not empty: count−1, dout←entry at index count−2, or 0 if the stack becomes empty.
  - 01, empty: no change, unf error event.
  - 11, not empty (including full): replace top. Entry count−1 ← din, dout←din, count unchanged, no error.
  - 11, empty: treated as plain push. Count becomes 1, dout←din, no unf.
- empty and full are registered and always consistent with count. They never assert together.
- Count arithmetic is unsigned CNT_W. Count never wraps past DEPTH or below 0.
- Error reporting without the macro: ovf/unf are one-cycle pulses, high for exactly the cycle after the rejected edge.

## Timing
- All outputs are registered. Latency is one clk edge from request sample to updated dout/count/flags.
- Back-to-back push or pop on consecutive cycles is supported at full rate, with no bubbles.
- dout reflects the new top in the cycle after a pop. No combinational path from push/pop/din to any output.
- No handshake or back-pressure: a rejected request is dropped, and the error flag is its only trace.
- Release of rst_n takes effect at the next rising clk edge; requests on that edge are honoured.

## Configuration
- STACK_ERR_STICKY_EN defined: ovf/unf are sticky. They set on a rejected request and stay high until err_clr is sampled high. If err_clr and a new error event occur on the same edge, the error wins and the flag stays high. Reset clears them.
- STACK_ERR_STICKY_EN undefined: ovf/unf are single-cycle pulses, err_clr is ignored.

## Test plan
All scenarios use DATA_W=16, DEPTH=8.
- Reset then pop on empty -> dout=0000, count=0, empty=1; unf pulses one cycle (sticky build: stays high until err_clr).
- Push ffaa, f66f, ff9f, 0000, 666f, 1234, 9876, abcd -> count=8, full=1, dout=abcd. A ninth push of 5555 -> count stays 8, dout=abcd, ovf asserted.
- From full, eight pops -> dout sequence 9876, 1234, 666f, 0000, ff9f, f66f, ffaa, 0000; final empty=1, count=0. A ninth pop -> unf asserted.
- Push 1111, 2222, then push+pop with din=3333 -> count=2, dout=3333; then pop -> dout=1111. At full, push+pop of 7777 -> dout=7777, count=8, no ovf.
- Push+pop on empty with din=4444 -> count=1, dout=4444, unf=0.
- Fill 3 entries, assert rst_n low between edges -> outputs return to reset values immediately. Release, push beef -> count=1, dout=beef.
